// File: rtl/pipe_ifid_queue.sv
// pipe_ifid_queue: DEPTH-entry in-order IF/ID instruction queue with flush-to-NOP.
// Build option IFID_FULL_PASS_EN lets a full queue accept a push in a cycle that also pops.
module pipe_ifid_queue #(
  parameter int unsigned        INSTR_W   = 16,
  parameter int unsigned        PC_W      = 16,
  parameter int unsigned        DEPTH     = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'hC000
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       valid_i,
  input  logic [INSTR_W-1:0]         instr_i,
  input  logic [PC_W-1:0]            pc_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  output logic                       full_o,
  output logic                       valid_o,
  output logic [INSTR_W-1:0]         instr_o,
  output logic [PC_W-1:0]            pc_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = INSTR_W + PC_W;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] wr_next;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic          at_cap;
  logic          push;
  logic          pop;

  // Pointers wrap explicitly so non-power-of-two depths never skip an entry.
  always_comb begin
    rd_next = (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
    wr_next = (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
  end

  assign at_cap  = (count == FULL_CNT);
  assign valid_o = (count != '0);
  assign pop     = valid_o && !stall_i && !flush_i;

`ifdef IFID_FULL_PASS_EN
  assign full_o = at_cap && !pop;
`else
  assign full_o = at_cap;
`endif

  assign push    = valid_i && !full_o && !flush_i;
  assign head    = mem[rd_ptr];
  assign instr_o = valid_o ? head[EW-1:PC_W] : NOP_INSTR;
  assign pc_o    = valid_o ? head[PC_W-1:0]  : '0;
  assign count_o = count;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush_i) begin
      // Array contents are left stale; count=0 already hides them.
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {instr_i, pc_i};
        wr_ptr      <= wr_next;
      end
      if (pop) begin
        rd_ptr <= rd_next;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ifid_queue.sv
// Bench for pipe_ifid_queue: DEPTH=2 and DEPTH=3 instances share stimulus, each
// checked against its own queue-based reference model.
module tb_pipe_ifid_queue;

  logic        clk_i   = 1'b0;
  logic        rst_n   = 1'b0;
  logic        valid_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [15:0] instr_i = '0;
  logic [15:0] pc_i    = '0;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef IFID_FULL_PASS_EN
  localparam bit PASS = 1'b1;
`else
  localparam bit PASS = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  task automatic check(input int d, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (DEPTH=%0d): got %0h, expected %0h", name, d, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int D  = g + 2;
    localparam int CW = $clog2(D + 1);

    logic          full;
    logic          valid;
    logic [15:0]   instr;
    logic [15:0]   pc;
    logic [CW-1:0] count;
    logic [31:0]   sb [$];

    pipe_ifid_queue #(
      .INSTR_W  (16),
      .PC_W     (16),
      .DEPTH    (D),
      .NOP_INSTR(16'hC000)
    ) dut (
      .clk_i  (clk_i),
      .rst_n  (rst_n),
      .valid_i(valid_i),
      .instr_i(instr_i),
      .pc_i   (pc_i),
      .stall_i(stall_i),
      .flush_i(flush_i),
      .full_o (full),
      .valid_o(valid),
      .instr_o(instr),
      .pc_o   (pc),
      .count_o(count)
    );

    // Monitor: compare the presented head and occupancy against the model.
    always @(negedge clk_i) begin : mon
      int          sz;
      bit          full_m;
      logic [31:0] head;
      sz     = sb.size();
      full_m = (sz == D) && !(PASS && sz != 0 && !stall_i && !flush_i);
      check(D, "valid", 32'(valid), 32'(sz != 0));
      check(D, "count", 32'(count), 32'(sz));
      check(D, "full", 32'(full), 32'(full_m));
      if (sz != 0) begin
        head = sb[0];
        check(D, "instr", 32'(instr), 32'(head[31:16]));
        check(D, "pc", 32'(pc), 32'(head[15:0]));
      end else begin
        check(D, "instr_nop", 32'(instr), 32'h0000_C000);
        check(D, "pc_zero", 32'(pc), 32'h0);
      end
    end

    // Reference model: accepted pushes enqueue, decode consumes from the front.
    always @(negedge clk_i) begin : mdl
      int sz;
      bit pop_m;
      bit full_m;
      #1;
      sz = sb.size();
      if (!rst_n || flush_i) begin
        sb.delete();
      end else begin
        pop_m  = (sz != 0) && !stall_i;
        full_m = (sz == D) && !(PASS && pop_m);
        if (pop_m) void'(sb.pop_front());
        if (valid_i && !full_m) sb.push_back({instr_i, pc_i});
      end
    end

    always @(negedge rst_n) sb.delete();
  end

  task automatic drive(input bit v, input logic [15:0] ins, input logic [15:0] p,
                       input bit st, input bit fl);
    @(posedge clk_i);
    #1;
    valid_i = v;
    instr_i = ins;
    pc_i    = p;
    stall_i = st;
    flush_i = fl;
  endtask

  task automatic reset_values();
    check(2, "rst_valid", 32'(u[0].valid), 32'h0);
    check(2, "rst_instr", 32'(u[0].instr), 32'h0000_C000);
    check(2, "rst_pc",    32'(u[0].pc),    32'h0);
    check(2, "rst_count", 32'(u[0].count), 32'h0);
    check(2, "rst_full",  32'(u[0].full),  32'h0);
    check(3, "rst_valid", 32'(u[1].valid), 32'h0);
    check(3, "rst_instr", 32'(u[1].instr), 32'h0000_C000);
    check(3, "rst_pc",    32'(u[1].pc),    32'h0);
    check(3, "rst_count", 32'(u[1].count), 32'h0);
    check(3, "rst_full",  32'(u[1].full),  32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    #2;
    reset_values();
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;

    // Single push, then empty again.
    drive(1'b1, 16'h1234, 16'd2, 1'b0, 1'b0);
    idle(3);

    // Stalled pushes A, B, C; DEPTH=2 drops C.
    drive(1'b1, 16'hA001, 16'd10, 1'b1, 1'b0);
    drive(1'b1, 16'hB002, 16'd12, 1'b1, 1'b0);
    drive(1'b1, 16'hC003, 16'd14, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle(5);

    // Two entries buffered, then flush with a concurrent push of D.
    drive(1'b1, 16'h1111, 16'd20, 1'b1, 1'b0);
    drive(1'b1, 16'h2222, 16'd22, 1'b1, 1'b0);
    drive(1'b1, 16'hD00D, 16'd24, 1'b1, 1'b1);
    idle(3);

    // Fill to capacity, then push while popping.
    for (int i = 0; i < 3; i++) drive(1'b1, 16'(16'h3000 + i), 16'(30 + 2 * i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'h4000 + i), 16'(40 + 2 * i), 1'b0, 1'b0);
    idle(5);

    // Back-to-back push/pop across pointer wrap.
    for (int i = 0; i < 10; i++) drive(1'b1, 16'(16'h5000 + i), 16'(50 + 2 * i), 1'b0, 1'b0);
    idle(5);

    // Full and stalled, then asynchronous reset mid-cycle.
    for (int i = 0; i < 4; i++) drive(1'b1, 16'(16'h6000 + i), 16'(60 + 2 * i), 1'b1, 1'b0);
    @(posedge clk_i);
    #3;
    rst_n   = 1'b0;
    valid_i = 1'b0;
    #1;
    reset_values();
    @(posedge clk_i);
    #1;
    rst_n   = 1'b1;
    stall_i = 1'b0;
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom),
            $urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0);
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ifid_queue.md
# pipe_ifid_queue

Parametrised IF/ID boundary for the 16-bit pipelined CPU. It generalises the single IF/ID register into a DEPTH-entry in-order instruction queue with a valid bit, so fetch can keep running while decode is stalled. On a control-hazard flush it discards every buffered entry and presents the NOP encoding to decode. It sits between the instruction-memory/PC+2 adder outputs and the decode stage.

## Interface
Parameters:
- INSTR_W, 16, instruction width
- PC_W, 16, width of the PC+2 value carried with each instruction
- DEPTH, 2, number of queue entries; legal range 2..8, need not be a power of two
- NOP_INSTR, 16'hC000, encoding driven on instr_o when the queue is empty (bne r0,r0,0)

Ports:
- clk_i, input, 1, clock; all state updates on posedge
- rst_n, input, 1, reset, asynchronous, active-low
- valid_i, input, 1, fetch presents a valid instruction this cycle
- instr_i, input, INSTR_W, fetched instruction
- pc_i, input, PC_W, PC+2 of the fetched instruction
- stall_i, input, 1, decode data hazard; head entry is not consumed
- flush_i, input, 1, control hazard; discard all entries
- full_o, output, 1, queue cannot accept a push this cycle; fetch must hold PC
- valid_o, output, 1, head entry is valid
- instr_o, output, INSTR_W, head instruction, or NOP_INSTR when empty
- pc_o, output, PC_W, head PC+2, or 0 when empty
- count_o, output, $clog2(DEPTH+1), number of occupied entries

## Operation
- Storage: DEPTH × (INSTR_W+PC_W) array, plus rd_ptr, wr_ptr and count.
- Each pointer wraps explicitly from DEPTH-1 to 0.
- valid_o = (count != 0). instr_o/pc_o come from the array at rd_ptr, muxed to NOP_INSTR/0 when empty.
- push = valid_i && !full_o && !flush_i.
- pop = valid_o && !stall_i && !flush_i.
- Push writes at wr_ptr and advances it. Pop advances rd_ptr.
- count update: push only → count+1; pop only → count−1; both or neither → unchanged.
- full_o = (count == DEPTH), except as modified by IFID_FULL_PASS_EN.
- A push offered while full_o=1 is ignored; no state changes and no error is flagged. Fetch is responsible for re-presenting the instruction.
- Flush dominates: on the next edge, count=0 and rd_ptr=wr_ptr=0, and any push or pop in the same cycle is discarded. Array contents are not cleared.
- Stall with empty queue has no effect. Stall and flush together resolve as flush.
- Reset (asynchronous, any time, including mid-stall or mid-flush):
  - pointers, count and all array entries go to 0
  - outputs: valid_o=0, instr_o=NOP_INSTR, pc_o=0, count_o=0, full_o=0

## Timing
- Latency: an instruction pushed at edge N, into an empty queue, appears on instr_o/pc_o with valid_o=1 after edge N. Decode samples it at edge N+1.
- Throughput: one push and one pop per cycle sustained; count is steady in that case.
- All outputs are registered-state derived, with no combinational path from any input. The exception is full_o when IFID_FULL_PASS_EN is set.
- Flush asserted in cycle N: valid_o=0 and instr_o=NOP_INSTR from after edge N. The first post-flush push can occur in cycle N+1.
- Stall held for k cycles keeps instr_o/pc_o constant for those k cycles. The queue keeps filling until full_o.

## Configuration
- IFID_FULL_PASS_EN defined:
  - full_o = (count == DEPTH) && !(valid_o && !stall_i && !flush_i)
  - when full with a same-cycle pop, a push is accepted and count stays DEPTH
  - full_o becomes combinationally dependent on stall_i and flush_i
- IFID_FULL_PASS_EN undefined:
  - full_o = (count == DEPTH), purely registered
  - a full queue refuses pushes even when popping that cycle, costing one bubble

## Test plan
- Reset, then push A=16'h1234/pc 2 with stall_i=0 → next cycle valid_o=1, instr_o=16'h1234, pc_o=2; following cycle, with no push, valid_o=0 and instr_o=16'hC000.
- DEPTH=2, stall_i=1, push A, B, C on consecutive cycles → count_o reaches 2, full_o=1, C is dropped. Release the stall → decode sees A then B, then NOP.
- Queue holds 2 entries, flush_i=1 together with valid_i and push D → next cycle count_o=0, valid_o=0, instr_o=16'hC000, and D is absent.
- Full queue, stall_i=0, valid_i=1: without the macro, count_o stays 2→1 (push refused, pop taken); with IFID_FULL_PASS_EN, count_o stays 2 and the new entry is queued behind.
- DEPTH=3, 10 back-to-back push/pop cycles → pointers wrap without skipping or duplicating entries, and the output order matches the input order exactly.
- rst_n pulsed low mid-cycle while full and stalled → outputs go to their reset values immediately, without waiting for a clock edge, and the queue stays empty after release.
